ledn_drv: RTL and testbench

Parametrised N-wide LED pattern driver with four selectable animation modes, a programmable step prescaler, pause/resume on `en`, and a pattern-wrap strobe. It is the generalised successor of the fixed 16-LED driver. It sits between board-level control logic (mode/rate registers, enable) and the LED pins. All outputs are registered.

---
 rtl/ledn_drv.sv | 133 +++++++++++++
 tb/tb_ledn_drv.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ledn_drv.sv
// ledn_drv: N-wide LED pattern driver with ROTATE/BOUNCE/FILL/BLINK modes,
// a step prescaler, pause on en and a one-cycle wrap strobe.
// Revision: 1.0
`default_nettype none

module ledn_drv #(
  parameter int N     = 16,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic [N-1:0]     led,
  output logic             wrap
);

  localparam int PW = $clog2(N);
  localparam int LW = $clog2(N + 1);
  localparam logic [PW-1:0] POS_LAST = PW'(N - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(N);

  typedef enum logic [1:0] {
    ROTATE = 2'd0,
    BOUNCE = 2'd1,
    FILL   = 2'd2,
    BLINK  = 2'd3
  } mode_t;

  mode_t            mode_q;
  logic [PW-1:0]    pos;
  logic             dir;      // 0 = up, 1 = down (shared by BOUNCE and FILL)
  logic [LW-1:0]    level;
  logic             phase;
  logic [DIV_W-1:0] cnt;

  logic [PW-1:0]    pos_nx;
  logic             dir_nx;
  logic [LW-1:0]    level_nx;
  logic             phase_nx;
  logic             at_start;
  logic [N-1:0]     onehot;
  logic [N-1:0]     fill_mask;
  logic [N-1:0]     disp;

  // Next pattern state, and whether it equals the start state of the mode
  always_comb begin
    pos_nx   = pos;
    dir_nx   = dir;
    level_nx = level;
    phase_nx = phase;
    at_start = 1'b0;
    case (mode_q)
      ROTATE: begin
        pos_nx   = (pos == POS_LAST) ? '0 : pos + PW'(1);
        at_start = (pos_nx == '0);
      end
      BOUNCE: begin
        if (!dir) begin
          pos_nx = pos + PW'(1);
          dir_nx = (pos_nx == POS_LAST);
        end else begin
          pos_nx = pos - PW'(1);
          dir_nx = (pos_nx != '0);
        end
        at_start = (pos_nx == '0) && !dir_nx;
      end
      FILL: begin
        if (!dir) begin
          level_nx = level + LW'(1);
          dir_nx   = (level_nx == LVL_FULL);
        end else begin
          level_nx = level - LW'(1);
          dir_nx   = (level_nx != '0);
        end
        at_start = (level_nx == '0) && !dir_nx;
      end
      BLINK: begin
        phase_nx = ~phase;
        at_start = !phase_nx;
      end
    endcase
  end

  for (genvar i = 0; i < N; i++) begin : g_disp
    assign onehot[i]    = (pos == PW'(i));
    assign fill_mask[i] = (level > LW'(i));
  end

  always_comb begin
    disp = '0;
    case (mode_q)
      ROTATE, BOUNCE: disp = onehot;
      FILL:           disp = fill_mask;
      BLINK:          disp = phase ? '0 : '1;
    endcase
  end

  // Reset and mode change share one path so rst+mode change gives the same result
  always_ff @(posedge clk) begin
    if (rst || (mode_t'(mode) != mode_q)) begin
      mode_q <= mode_t'(mode);
      pos    <= '0;
      dir    <= 1'b0;
      level  <= '0;
      phase  <= 1'b0;
      cnt    <= '0;
      led    <= '0;
      wrap   <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      led  <= '0;
      wrap <= 1'b0;
    end else begin
      led <= disp;
      if (cnt == div) begin
        cnt   <= '0;
        pos   <= pos_nx;
        dir   <= dir_nx;
        level <= level_nx;
        phase <= phase_nx;
        wrap  <= at_start;
      end else begin
        cnt  <= cnt + DIV_W'(1);
        wrap <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ledn_drv.sv
// Randomised bench for ledn_drv at N=16/8/4/2 against an index-based pattern model.
`default_nettype none

module tb_ledn_drv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [23:0] div;

  logic [15:0] led16;
  logic [7:0]  led8;
  logic [3:0]  led4;
  logic [1:0]  led2;
  logic [3:0]  wrap_v;

  ledn_drv #(.N(16), .DIV_W(24)) u16 (.clk(clk), .rst(rst), .en(en), .mode(mode), .div(div), .led(led16), .wrap(wrap_v[0]));
  ledn_drv #(.N(8),  .DIV_W(24)) u8  (.clk(clk), .rst(rst), .en(en), .mode(mode), .div(div), .led(led8),  .wrap(wrap_v[1]));
  ledn_drv #(.N(4),  .DIV_W(24)) u4  (.clk(clk), .rst(rst), .en(en), .mode(mode), .div(div), .led(led4),  .wrap(wrap_v[2]));
  ledn_drv #(.N(2),  .DIV_W(24)) u2  (.clk(clk), .rst(rst), .en(en), .mode(mode), .div(div), .led(led2),  .wrap(wrap_v[3]));

  logic [63:0] led_obs [4];
  assign led_obs[0] = {48'b0, led16};
  assign led_obs[1] = {56'b0, led8};
  assign led_obs[2] = {60'b0, led4};
  assign led_obs[3] = {62'b0, led2};

  int n_cmp = 0;
  int n_err = 0;

  // Model: k is the step index within the period, m the cycles spent on it
  int          nn [4] = '{16, 8, 4, 2};
  int          k  [4];
  int          m  [4];
  logic [1:0]  mq [4];
  logic [63:0] want_led  [4];
  logic        want_wrap [4];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, want, $time);
    end
  endtask

  function automatic int period(input int n, input logic [1:0] md);
    case (md)
      2'd0:    return n;
      2'd1:    return 2 * n - 2;
      2'd2:    return 2 * n;
      default: return 2;
    endcase
  endfunction

  function automatic logic [63:0] pattern(input int n, input logic [1:0] md, input int kk);
    int p;
    case (md)
      2'd0: return 64'd1 << kk;
      2'd1: begin
        p = (kk < n) ? kk : 2 * n - 2 - kk;
        return 64'd1 << p;
      end
      2'd2: begin
        p = (kk <= n) ? kk : 2 * n - kk;
        return (64'd1 << p) - 64'd1;
      end
      default: return (kk == 0) ? (64'd1 << n) - 64'd1 : 64'd0;
    endcase
  endfunction

  task automatic model_step(input int d);
    if (rst || (mode != mq[d])) begin
      mq[d] = mode;
      k[d] = 0;
      m[d] = 0;
      want_led[d] = '0;
      want_wrap[d] = 1'b0;
    end else if (!en) begin
      m[d] = 0;
      want_led[d] = '0;
      want_wrap[d] = 1'b0;
    end else begin
      want_led[d] = pattern(nn[d], mq[d], k[d]);
      if (m[d] == int'(div)) begin
        m[d] = 0;
        k[d] = (k[d] + 1) % period(nn[d], mq[d]);
        want_wrap[d] = (k[d] == 0);
      end else begin
        m[d]++;
        want_wrap[d] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 4; d++) model_step(d);
    #1;
    for (int d = 0; d < 4; d++) begin
      check_eq($sformatf("led_n%0d", nn[d]), led_obs[d], want_led[d]);
      check_eq($sformatf("wrap_n%0d", nn[d]), {63'b0, wrap_v[d]}, {63'b0, want_wrap[d]});
    end
  endtask

  task automatic run_until16(input logic [15:0] val, input string tag);
    int t = 0;
    while (led16 !== val && t < 64) begin
      tick();
      t++;
    end
    check_eq(tag, {48'b0, led16}, {48'b0, val});
  endtask

  initial begin
    int wr;
    int len;
    rst = 1'b1; en = 1'b0; mode = 2'd0; div = '0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();

    // ROTATE div=0: wrap every 16 cycles on the 0x8000 display
    en = 1'b1;
    wr = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (wrap_v[0]) wr++;
    end
    check_eq("rot_wraps", 64'(wr), 64'd2);

    // Pause on 0x0010 and resume at 0x0020
    run_until16(16'h0010, "pause_reach");
    en = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    tick();
    check_eq("resume", {48'b0, led16}, 64'h20);
    repeat (3) tick();

    // BOUNCE then FILL
    mode = 2'd1;
    repeat (32) tick();
    mode = 2'd2;
    repeat (36) tick();

    // BLINK with div=3
    en = 1'b0; div = 24'd3; mode = 2'd3;
    tick();
    en = 1'b1;
    repeat (24) tick();

    // ROTATE -> BLINK switch at 0x0100
    en = 1'b0; div = 24'd0; mode = 2'd0;
    tick();
    en = 1'b1;
    run_until16(16'h0100, "mc_reach");
    mode = 2'd3;
    tick();
    check_eq("mc_blank", {48'b0, led16}, 64'h0);
    tick();
    check_eq("mc_blink", {48'b0, led16}, 64'hFFFF);

    // Reset mid-FILL
    mode = 2'd2;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();

    // Random segments; div only changes while paused
    for (int s = 0; s < 250; s++) begin
      en = 1'b0;
      div = 24'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 15) == 0);
      tick();
      rst = 1'b0;
      len = $urandom_range(1, 30);
      for (int c = 0; c < len; c++) begin
        en = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
